// File: rtl/bin2bcd_seq_pkg.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq_pkg : shared state encodings and BCD correction constants. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESHOLD = 4'd5;
  localparam logic [3:0] BCD_ADJ_VALUE     = 4'd3;

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq_if.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq_if : request/result bundle for the binary-to-BCD converter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface bin2bcd_seq_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
);

  logic                  iStart;
  logic [WIDTH-1:0]      iBin;
  logic                  oBusy;
  logic                  oDone;
  logic [4*DIGITS-1:0]   oBCD;
  logic                  oOverflow;

  modport master (
    output iStart, iBin,
    input  oBusy, oDone, oBCD, oOverflow
  );

  modport slave (
    input  iStart, iBin,
    output oBusy, oDone, oBCD, oOverflow
  );

endinterface

`default_nettype wire

// File: rtl/bin2bcd_seq_add3.sv
// ----------------------------------------------------------------------------
// bcd_add3 : single-digit shift-and-add-3 corrector (in >= 5 ? in + 3 : in). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bcd_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Working digits never exceed 9, so the sum stays within 4 bits.
  assign digit_o = (digit_i >= BCD_ADJ_THRESHOLD) ? (digit_i + BCD_ADJ_VALUE) : digit_i;

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq : sequential double-dabble binary-to-BCD converter, 1 bit/clock. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic            iCLK,
  input  logic            iRST_n,
  bin2bcd_seq_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     bin_q;
  logic [BCD_W-1:0]     bcd_q;
  logic                 ovf_q;
  logic                 busy_q;
  logic                 done_q;
  logic [BCD_W-1:0]     bcd_out_q;
  logic                 ovf_out_q;

  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     bcd_d;
  logic                 ovf_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  // Shift {BCD, binary} left; the bit leaving the top digit means the value
  // does not fit in DIGITS digits and is latched into the sticky overflow.
  assign bcd_d = {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
  assign ovf_d = ovf_q | bcd_adj[BCD_W-1];

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_out_q <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.iStart) begin
            bin_q   <= bus.iBin;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= CNT_W'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          bin_q <= bin_q << 1;
          bcd_q <= bcd_d;
          ovf_q <= ovf_d;
          cnt_q <= cnt_q - CNT_W'(1);
          // Results are registered on the final shift so they are valid for
          // the whole DONE cycle alongside the done pulse.
          if (cnt_q == CNT_W'(1)) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            bcd_out_q <= bcd_d;
            ovf_out_q <= ovf_d;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.oBusy     = busy_q;
  assign bus.oDone     = done_q;
  assign bus.oBCD      = bcd_out_q;
  assign bus.oOverflow = ovf_out_q;

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// tb_bin2bcd_seq : randomized bench for bin2bcd_seq, 10-digit and 4-digit builds. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bin2bcd_seq;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  bin2bcd_seq_if #(.WIDTH(W), .DIGITS(10)) a ();
  bin2bcd_seq_if #(.WIDTH(W), .DIGITS(4))  b ();

  bin2bcd_seq #(.WIDTH(W), .DIGITS(10)) u_dut10 (
    .iCLK   (clk),
    .iRST_n (rst_n),
    .bus    (a.slave)
  );

  bin2bcd_seq #(.WIDTH(W), .DIGITS(4)) u_dut4 (
    .iCLK   (clk),
    .iRST_n (rst_n),
    .bus    (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal digits of v, least significant first, as packed nibbles.
  function automatic logic [63:0] ref_bcd(input logic [31:0] v, input int nd);
    logic [63:0]     r;
    longint unsigned x;
    r = '0;
    x = {32'd0, v};
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [31:0] v, input int nd);
    longint unsigned lim;
    lim = 1;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    return ({32'd0, v} >= lim);
  endfunction

  task automatic drive(input logic s, input logic [31:0] v);
    a.iStart = s; b.iStart = s;
    a.iBin   = v; b.iBin   = v;
  endtask

  // One conversion on both builds; optional stray start pulse mid-conversion.
  task automatic run(input logic [31:0] v, input bit mid, input string tag);
    int          busy_n, done_a, done_b, lat;
    bit          hold_ok;
    logic [39:0] prev_a, got_a;
    logic [15:0] prev_b, got_b;
    logic        ovf_a, ovf_b;
    busy_n = 0; done_a = 0; done_b = 0; lat = -1; hold_ok = 1'b1;
    got_a = 'x; got_b = 'x; ovf_a = 1'bx; ovf_b = 1'bx;
    @(negedge clk);
    prev_a = a.oBCD; prev_b = b.oBCD;
    drive(1'b1, v);
    @(negedge clk);
    drive(1'b0, $urandom);
    for (int cyc = 1; cyc <= W + 3; cyc++) begin
      if (a.oBusy) busy_n++;
      if (b.oDone) begin done_b++; got_b = b.oBCD; ovf_b = b.oOverflow; end
      if (a.oDone) begin
        done_a++; lat = cyc; got_a = a.oBCD; ovf_a = a.oOverflow;
      end else if (done_a == 0 && (a.oBCD !== prev_a || b.oBCD !== prev_b)) begin
        hold_ok = 1'b0;
      end
      if (mid && cyc == 5) drive(1'b1, 32'd77);
      if (mid && cyc == 6) drive(1'b0, $urandom);
      @(negedge clk);
    end
    chk({tag, " latency"}, 64'(lat), 64'(W + 1));
    chk({tag, " busy_cycles"}, 64'(busy_n), 64'(W + 1));
    chk({tag, " done_pulses"}, 64'(done_a + done_b), 64'd2);
    chk({tag, " result_hold"}, 64'(hold_ok), 64'd1);
    chk({tag, " bcd10"}, 64'(got_a), ref_bcd(v, 10));
    chk({tag, " ovf10"}, 64'(ovf_a), 64'(ref_ovf(v, 10)));
    chk({tag, " bcd4"}, 64'(got_b), ref_bcd(v, 4));
    chk({tag, " ovf4"}, 64'(ovf_b), 64'(ref_ovf(v, 4)));
    chk({tag, " idle_after"}, 64'({a.oBusy, a.oDone}), 64'd0);
  endtask

  initial begin
    logic [31:0] v;
    int          done_at [3];
    int          nd;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    drive(1'b1, 32'd123);
    repeat (3) @(negedge clk);
    chk("reset_outputs10", {a.oBusy, a.oDone, a.oOverflow, a.oBCD}, 64'd0);
    chk("reset_outputs4", {b.oBusy, b.oDone, b.oOverflow, b.oBCD}, 64'd0);
    drive(1'b0, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_accept_in_reset", 64'(a.oBusy), 64'd0);

    run(32'd0,          1'b0, "zero");
    run(32'd1234,       1'b0, "v1234");
    run(32'hFFFF_FFFF,  1'b0, "max");
    run(32'd12345,      1'b0, "v12345");
    run(32'd9999,       1'b0, "v9999");
    run(32'd10000,      1'b0, "v10000");
    run(32'd999999999,  1'b0, "v999999999");
    run(32'd42,         1'b1, "ignore_mid_start");

    for (int i = 0; i < 16; i++) begin
      case (i % 3)
        0:       v = $urandom;
        1:       v = $urandom_range(0, 99999);
        default: v = $urandom_range(0, 9999);
      endcase
      run(v, (i % 4) == 3, "random");
    end

    // Continuous start: accepts every W+2 cycles, each result correct.
    v = $urandom;
    nd = 0;
    @(negedge clk);
    drive(1'b1, v);
    for (int cyc = 1; cyc <= 3 * (W + 2) + 4; cyc++) begin
      @(negedge clk);
      if (a.oDone && nd < 3) begin
        done_at[nd] = cyc;
        nd++;
        chk("b2b_bcd10", 64'(a.oBCD), ref_bcd(v, 10));
        if (nd == 3) drive(1'b0, 32'd0);
      end
    end
    chk("b2b_done_count", 64'(nd), 64'd3);
    if (nd == 3) begin
      chk("b2b_spacing1", 64'(done_at[1] - done_at[0]), 64'(W + 2));
      chk("b2b_spacing2", 64'(done_at[2] - done_at[1]), 64'(W + 2));
    end
    repeat (4) @(negedge clk);

    // Abort mid-conversion with reset.
    run(32'd987654, 1'b0, "pre_abort");
    @(negedge clk);
    drive(1'b1, 32'd500);
    @(negedge clk);
    drive(1'b0, 32'd0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs10", {a.oBusy, a.oDone, a.oOverflow, a.oBCD}, 64'd0);
    chk("abort_outputs4", {b.oBusy, b.oDone, b.oOverflow, b.oBCD}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int cyc = 0; cyc < W + 8; cyc++) begin
      @(negedge clk);
      if (a.oDone || b.oDone || a.oBusy) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    run(32'd500, 1'b0, "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
